chase_step_ctrl: RTL
====================

Name: chase_step_ctrl

Overview:
Front-end control stage that sits directly upstream of the LED chaser and drives that block's enable input.
- Conditions three raw pushbuttons: synchronise, debounce, detect the press edge.
- Maintains a run/stop flag and a speed level.
- Emits a one-cycle step pulse at a programmable period; each pulse advances the chaser exactly one position.

Parameters:
DEBOUNCE_CYC, 16, consecutive differing samples needed before a debounced button changes state (>=2)
BASE_DIV, 1024, step period in clk cycles at speed level 0 (>=2)
MAX_LEVEL, 7, slowest speed level; step period = BASE_DIV << level
DEFAULT_LEVEL, 3, speed level after reset (<= MAX_LEVEL)
LVL_W, 3, width of speed_level; must hold MAX_LEVEL

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  reset
btn_run_raw  input  1  asynchronous run/stop pushbutton, active high
btn_up_raw  input  1  asynchronous "faster" pushbutton, active high
btn_dn_raw  input  1  asynchronous "slower" pushbutton, active high
step_en  output  1  one-cycle pulse, connects to the chaser's enable input
running  output  1  1 = stepping active
speed_level  output  LVL_W  current level, 0 = fastest

Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low. The following are registered and take their reset values immediately on rst_n low:
- running=0, speed_level=DEFAULT_LEVEL, step_en=0
- all synchronisers, debounce states, debounce counters and the prescaler = 0

Behaviour:
- Synchronisation: each raw button passes through a 2-flop synchroniser (sync1, sync2).
- Debounce:
  - db_state updates to sync2 on the DEBOUNCE_CYC-th consecutive edge at which sync2 != db_state.
  - The counter clears on any edge where sync2 == db_state.
  - Glitches shorter than DEBOUNCE_CYC cycles are discarded.
- Press pulse: a 1-cycle pulse when db_state goes 0->1. Release (1->0) generates nothing.
- Latency: a clean raw rise sampled at edge 1 changes running/speed_level at edge DEBOUNCE_CYC+3.
- run press: running toggles.
- up press: speed_level decrements, saturating at 0.
- dn press: speed_level increments, saturating at MAX_LEVEL.
- Simultaneous up and dn press pulses in the same cycle: both ignored, level unchanged. A run press in that same cycle is still honoured.
- Prescaler:
  - Counter width is sized to hold (BASE_DIV<<MAX_LEVEL)-1.
  - While running=0: counter held at 0, step_en=0.
  - While running=1: counter increments each cycle. On the edge where counter == (BASE_DIV<<speed_level)-1, the counter wraps to 0 and step_en=1 for the following cycle only.
  - First step_en after running rises appears exactly BASE_DIV<<level cycles later. Pulses then repeat at that period, with no drift.
- Level change:
  - Any edge that changes speed_level also clears the counter, so the new period restarts from 0.
  - No pulse is emitted on that edge, even if the terminal count coincides.
- Stop precedence: a run press that clears running on a terminal-count edge suppresses step_en for that edge.
- Start: a run press that sets running starts the counter at 0 on that edge.
- Saturation: a press at a limit changes nothing, including the counter.
- Reset mid-operation: all state returns to reset values asynchronously. A button held through reset deassertion must be seen as a new press once debounced.

Decomposition:
- Package chase_pkg holds:
  - LVL_W, MAX_LEVEL, DEFAULT_LEVEL constants
  - a function computing prescaler width from BASE_DIV and MAX_LEVEL
  - the level typedef, logic [LVL_W-1:0]
- Sub-module btn_debounce (params DEBOUNCE_CYC; ports clk, rst_n, raw, level, press) contains the synchroniser, debounce counter and rise detector. It is instantiated three times.
- Top-level holds the run/level control and the prescaler.

Test Plan (DEBOUNCE_CYC=4, BASE_DIV=4, MAX_LEVEL=3, DEFAULT_LEVEL=1 unless stated):
1. Reset with rst_n low mid-cycle -> all outputs at reset values immediately (running=0, speed_level=1, step_en=0). Release, run press held 10 cycles -> running=1 at edge 7; first step_en 8 cycles later; thereafter one pulse every 8 cycles, each exactly 1 cycle wide.
2. Run button bouncing: 3-cycle highs separated by 1-cycle lows for 20 cycles, then held high -> exactly one toggle, at edge 7 after the final rise.
3. While running at level 1: up press -> level 0, counter cleared; next step_en 4 cycles after the change edge. Then 3 dn presses -> level 3, next pulse 32 cycles after the last change.
4. Saturation: at level 0, up press -> level stays 0, pulse train undisturbed. At level 3, dn press -> stays 3.
5. up and dn raw rising on the same edge, identical duration -> level unchanged. run press on a terminal-count edge while running -> running=0, no step_en on that edge.
6. Assert rst_n low while running with step_en high -> step_en, running and counter clear immediately. Hold btn_up_raw through reset release -> level goes 1->0 at edge 7 after release.

Source files
------------

// File: rtl/chase_pkg.sv
// Shared constants, types and sizing helper for the chaser step controller.
package chase_pkg;

  localparam int LVL_W         = 3;
  localparam int MAX_LEVEL     = 7;
  localparam int DEFAULT_LEVEL = 3;

  typedef logic [LVL_W-1:0] level_t;

  // One bit per conditioned pushbutton; indexable as a 3-bit vector.
  typedef struct packed {
    logic dn;
    logic up;
    logic run;
  } btn_t;

  // Bits needed to hold (base_div << max_level) - 1.
  function automatic int presc_width(input int base_div, input int max_level);
    return $clog2(longint'(base_div) << max_level);
  endfunction

endpackage

// File: rtl/chase_step_ctrl_btn_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, counting debouncer and
// registered rising-edge press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYC);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        // Nth consecutive disagreement: accept the new level.
        cnt   <= '0;
        level <= sync[1];
        press <= sync[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/chase_step_ctrl.sv
// Run/speed control and step prescaler feeding the LED chaser enable.
module chase_step_ctrl #(
  parameter int DEBOUNCE_CYC  = 16,
  parameter int BASE_DIV      = 1024,
  parameter int MAX_LEVEL     = chase_pkg::MAX_LEVEL,
  parameter int DEFAULT_LEVEL = chase_pkg::DEFAULT_LEVEL,
  parameter int LVL_W         = chase_pkg::LVL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_run_raw,
  input  logic             btn_up_raw,
  input  logic             btn_dn_raw,
  output logic             step_en,
  output logic             running,
  output logic [LVL_W-1:0] speed_level
);

  import chase_pkg::*;

  localparam int               PW      = presc_width(BASE_DIV, MAX_LEVEL);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(MAX_LEVEL);
  localparam logic [LVL_W-1:0] LVL_DEF = LVL_W'(DEFAULT_LEVEL);

  btn_t raw, press, db_lvl;

  assign raw = '{dn: btn_dn_raw, up: btn_up_raw, run: btn_run_raw};

  for (genvar i = 0; i < 3; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw[i]),
      .level (db_lvl[i]),
      .press (press[i])
    );
  end

  logic          lvl_dec, lvl_inc, lvl_chg, last_cnt;
  logic [PW-1:0] cnt, period_m1;

  // Opposing presses in the same cycle cancel; limits block the change.
  assign lvl_dec   = press.up & ~press.dn & (speed_level != '0);
  assign lvl_inc   = press.dn & ~press.up & (speed_level != LVL_MAX);
  assign lvl_chg   = lvl_dec | lvl_inc;
  assign period_m1 = PW'((BASE_DIV << speed_level) - 1);
  assign last_cnt  = (cnt == period_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running     <= 1'b0;
      speed_level <= LVL_DEF;
      cnt         <= '0;
      step_en     <= 1'b0;
    end else begin
      running <= running ^ press.run;
      if (lvl_dec)      speed_level <= speed_level - LVL_W'(1);
      else if (lvl_inc) speed_level <= speed_level + LVL_W'(1);
      // Start, stop and level changes all restart the period with no pulse.
      if (!running || press.run || lvl_chg) begin
        cnt     <= '0;
        step_en <= 1'b0;
      end else if (last_cnt) begin
        cnt     <= '0;
        step_en <= 1'b1;
      end else begin
        cnt     <= cnt + PW'(1);
        step_en <= 1'b0;
      end
    end
  end

endmodule
